// File: rtl/cpu_types_pkg.sv
// rtl/cpu_types_pkg.sv - shared types and control-vector constants for the hazard controller
package cpu_types_pkg;

    typedef enum logic [2:0] {
        RUN      = 3'd0,
        LU_STALL = 3'd1,
        MEM_WAIT = 3'd2,
        FLUSH    = 3'd3,
        HALTED   = 3'd4
    } hazard_state_t;

    typedef enum logic [1:0] {
        FWD_RF    = 2'b00,
        FWD_EXMEM = 2'b01,
        FWD_MEMWB = 2'b10
    } fwd_sel_t;

    // Per-stage enables followed by per-stage flushes (no flush exists for the PC).
    typedef struct packed {
        logic en_pc;
        logic en_ifid;
        logic en_idex;
        logic en_exmem;
        logic en_memwb;
        logic fl_ifid;
        logic fl_idex;
        logic fl_exmem;
        logic fl_memwb;
    } hz_ctrl_t;

    localparam hz_ctrl_t CTRL_RUN     = 9'b11111_0000;  // everything advances
    localparam hz_ctrl_t CTRL_HOLD    = 9'b00000_0000;  // whole pipe frozen
    localparam hz_ctrl_t CTRL_RESET   = 9'b00000_1111;  // frozen and every latch cleared
    localparam hz_ctrl_t CTRL_BUBBLE  = 9'b00111_0100;  // PC/IF-ID hold, bubble into EX
    localparam hz_ctrl_t CTRL_BRANCH  = 9'b11111_1110;  // redirect: kill the three younger stages
    localparam hz_ctrl_t CTRL_REFETCH = 9'b00000_1000;  // waiting on target fetch, keep IF/ID empty

    // Stall-counter preload after the first bubble; out-of-range values are clamped into 1..3.
    function automatic logic [1:0] lu_preload(input int bubbles);
        if (bubbles <= 1) return 2'd0;
        else if (bubbles >= 3) return 2'd2;
        else return 2'(bubbles - 1);
    endfunction

endpackage

// File: rtl/hazard_ctrl_p_if.sv
// rtl/hazard_ctrl_p_if.sv - pipeline status in, stage control out
interface hazard_ctrl_p_if import cpu_types_pkg::*; #(parameter int REG_W = 5);

    logic             ihit;
    logic             dhit;
    logic [REG_W-1:0] ifid_rs;
    logic [REG_W-1:0] ifid_rt;
    logic [REG_W-1:0] idex_rs;
    logic [REG_W-1:0] idex_rt;
    logic [REG_W-1:0] idex_rd;
    logic [REG_W-1:0] exmem_rd;
    logic [REG_W-1:0] memwb_rd;
    logic             idex_wen;
    logic             exmem_wen;
    logic             memwb_wen;
    logic             idex_dREN;
    logic             exmem_memreq;
    logic             branch_taken;
    logic             halt;

    logic             pc_enable;
    logic             ifid_enable;
    logic             idex_enable;
    logic             exmem_enable;
    logic             memwb_enable;
    logic             ifid_flush;
    logic             idex_flush;
    logic             exmem_flush;
    logic             memwb_flush;
    fwd_sel_t         fwd_a;
    fwd_sel_t         fwd_b;
    logic             halted;

    // Datapath side: reports pipeline status, consumes stage control.
    modport master (
        output ihit, dhit, ifid_rs, ifid_rt, idex_rs, idex_rt,
               idex_rd, exmem_rd, memwb_rd, idex_wen, exmem_wen, memwb_wen,
               idex_dREN, exmem_memreq, branch_taken, halt,
        input  pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               fwd_a, fwd_b, halted
    );

    // Hazard controller side.
    modport slave (
        input  ihit, dhit, ifid_rs, ifid_rt, idex_rs, idex_rt,
               idex_rd, exmem_rd, memwb_rd, idex_wen, exmem_wen, memwb_wen,
               idex_dREN, exmem_memreq, branch_taken, halt,
        output pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable,
               ifid_flush, idex_flush, exmem_flush, memwb_flush,
               fwd_a, fwd_b, halted
    );

endinterface

// File: rtl/hazard_fwd_sel.sv
// rtl/hazard_fwd_sel.sv - operand bypass select for one EX source register
module hazard_fwd_sel import cpu_types_pkg::*; #(
    parameter int REG_W  = 5,
    parameter int FWD_EN = 1
) (
    input  logic [REG_W-1:0] src_i,
    input  logic [REG_W-1:0] exmem_rd_i,
    input  logic             exmem_wen_i,
    input  logic [REG_W-1:0] memwb_rd_i,
    input  logic             memwb_wen_i,
    output fwd_sel_t         sel_o
);

    // Youngest producer wins; $0 is hard-wired and never bypassed.
    always_comb begin
        sel_o = FWD_RF;
        if (FWD_EN != 0 && src_i != '0) begin
            if (exmem_wen_i && exmem_rd_i == src_i) begin
                sel_o = FWD_EXMEM;
            end else if (memwb_wen_i && memwb_rd_i == src_i) begin
                sel_o = FWD_MEMWB;
            end
        end
    end

endmodule

// File: rtl/hazard_ctrl_p.sv
// rtl/hazard_ctrl_p.sv - 5-stage pipeline stall/flush/forward controller
module hazard_ctrl_p import cpu_types_pkg::*; #(
    parameter int REG_W   = 5,
    parameter int BUBBLES = 1,
    parameter int FWD_EN  = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    hazard_ctrl_p_if.slave        hz
);

    localparam logic [1:0] LU_INIT = lu_preload(BUBBLES);

    hazard_state_t state_q, state_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          halted_q, halted_d;
    hz_ctrl_t      ctrl;
    hz_ctrl_t      ctrl_out;
    fwd_sel_t      fwd_a_sel, fwd_b_sel;

    logic mem_miss, adv, load_use, raw_any;

    // A writing, non-zero destination that the ID instruction reads.
    function automatic logic reads_dest(input logic [REG_W-1:0] rd, input logic wen,
                                        input logic [REG_W-1:0] rs, input logic [REG_W-1:0] rt);
        return wen && (rd != '0) && (rd == rs || rd == rt);
    endfunction

    assign mem_miss = hz.exmem_memreq & ~hz.dhit;
    assign adv      = hz.ihit & ~mem_miss;
    assign load_use = hz.idex_dREN & reads_dest(hz.idex_rd, hz.idex_wen, hz.ifid_rs, hz.ifid_rt);
    // Without bypassing, any in-flight producer of an ID source must drain first.
    assign raw_any  = (FWD_EN == 0) &&
                      (reads_dest(hz.idex_rd,  hz.idex_wen,  hz.ifid_rs, hz.ifid_rt) ||
                       reads_dest(hz.exmem_rd, hz.exmem_wen, hz.ifid_rs, hz.ifid_rt) ||
                       reads_dest(hz.memwb_rd, hz.memwb_wen, hz.ifid_rs, hz.ifid_rt));

    // Next state and stage control, resolved halt > miss > branch > stall > run.
    always_comb begin
        ctrl     = CTRL_HOLD;
        state_d  = state_q;
        cnt_d    = cnt_q;
        halted_d = halted_q;

        if (state_q == HALTED || hz.halt) begin
            state_d  = HALTED;
            halted_d = 1'b1;
        end else if (mem_miss) begin
            // Any pending stall is abandoned; load-use is re-evaluated after the miss.
            state_d = MEM_WAIT;
            cnt_d   = 2'd0;
        end else if (!hz.ihit) begin
            if (state_q == FLUSH) begin
                ctrl = CTRL_REFETCH;
            end else if (state_q == MEM_WAIT) begin
                state_d = RUN;
            end
        end else if (hz.branch_taken) begin
            ctrl    = CTRL_BRANCH;
            state_d = FLUSH;
            cnt_d   = 2'd0;
        end else if (state_q == LU_STALL) begin
            ctrl    = CTRL_BUBBLE;
            cnt_d   = (cnt_q != 2'd0) ? cnt_q - 2'd1 : 2'd0;
            state_d = (cnt_q <= 2'd1) ? RUN : LU_STALL;
        end else if (load_use) begin
            // This cycle is the first bubble; the counter covers the rest.
            ctrl = CTRL_BUBBLE;
            if (BUBBLES > 1) begin
                state_d = LU_STALL;
                cnt_d   = LU_INIT;
            end else begin
                state_d = RUN;
            end
        end else if (raw_any) begin
            ctrl    = CTRL_BUBBLE;
            state_d = RUN;
        end else begin
            ctrl    = CTRL_RUN;
            state_d = RUN;
            cnt_d   = 2'd0;
        end
    end

    // State, stall counter and sticky halt; reset wins from any state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= RUN;
            cnt_q    <= 2'd0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            halted_q <= halted_d;
        end
    end

    hazard_fwd_sel #(.REG_W(REG_W), .FWD_EN(FWD_EN)) u_fwd_a (
        .src_i       (hz.idex_rs),
        .exmem_rd_i  (hz.exmem_rd),
        .exmem_wen_i (hz.exmem_wen),
        .memwb_rd_i  (hz.memwb_rd),
        .memwb_wen_i (hz.memwb_wen),
        .sel_o       (fwd_a_sel)
    );

    hazard_fwd_sel #(.REG_W(REG_W), .FWD_EN(FWD_EN)) u_fwd_b (
        .src_i       (hz.idex_rt),
        .exmem_rd_i  (hz.exmem_rd),
        .exmem_wen_i (hz.exmem_wen),
        .memwb_rd_i  (hz.memwb_rd),
        .memwb_wen_i (hz.memwb_wen),
        .sel_o       (fwd_b_sel)
    );

    assign ctrl_out = RST ? CTRL_RESET : ctrl;

    assign hz.pc_enable    = ctrl_out.en_pc;
    assign hz.ifid_enable  = ctrl_out.en_ifid;
    assign hz.idex_enable  = ctrl_out.en_idex;
    assign hz.exmem_enable = ctrl_out.en_exmem;
    assign hz.memwb_enable = ctrl_out.en_memwb;
    assign hz.ifid_flush   = ctrl_out.fl_ifid;
    assign hz.idex_flush   = ctrl_out.fl_idex;
    assign hz.exmem_flush  = ctrl_out.fl_exmem;
    assign hz.memwb_flush  = ctrl_out.fl_memwb;
    assign hz.fwd_a        = RST ? FWD_RF : fwd_a_sel;
    assign hz.fwd_b        = RST ? FWD_RF : fwd_b_sel;
    assign hz.halted       = ~RST & halted_d;

endmodule

// File: tb/tb_hazard_ctrl_p.sv
// tb/tb_hazard_ctrl_p.sv - directed vectors for hazard_ctrl_p
module tb_hazard_ctrl_p;

    localparam logic [8:0] RUNV = 9'b11111_0000;
    localparam logic [8:0] HLDV = 9'b00000_0000;
    localparam logic [8:0] RSTV = 9'b00000_1111;
    localparam logic [8:0] BUBV = 9'b00111_0100;
    localparam logic [8:0] BRV  = 9'b11111_1110;
    localparam logic [8:0] REFV = 9'b00000_1000;

    logic CLK, RST;
    logic ihit, dhit, idex_wen, exmem_wen, memwb_wen, idex_dREN, exmem_memreq, branch_taken, halt;
    logic [4:0] ifid_rs, ifid_rt, idex_rs, idex_rt, idex_rd, exmem_rd, memwb_rd;

    int n_vec = 0;
    int n_miss = 0;

    hazard_ctrl_p_if #(.REG_W(5)) ifa ();
    hazard_ctrl_p_if #(.REG_W(5)) ifb ();

    assign ifa.ihit = ihit;         assign ifb.ihit = ihit;
    assign ifa.dhit = dhit;         assign ifb.dhit = dhit;
    assign ifa.ifid_rs = ifid_rs;   assign ifb.ifid_rs = ifid_rs;
    assign ifa.ifid_rt = ifid_rt;   assign ifb.ifid_rt = ifid_rt;
    assign ifa.idex_rs = idex_rs;   assign ifb.idex_rs = idex_rs;
    assign ifa.idex_rt = idex_rt;   assign ifb.idex_rt = idex_rt;
    assign ifa.idex_rd = idex_rd;   assign ifb.idex_rd = idex_rd;
    assign ifa.exmem_rd = exmem_rd; assign ifb.exmem_rd = exmem_rd;
    assign ifa.memwb_rd = memwb_rd; assign ifb.memwb_rd = memwb_rd;
    assign ifa.idex_wen = idex_wen; assign ifb.idex_wen = idex_wen;
    assign ifa.exmem_wen = exmem_wen; assign ifb.exmem_wen = exmem_wen;
    assign ifa.memwb_wen = memwb_wen; assign ifb.memwb_wen = memwb_wen;
    assign ifa.idex_dREN = idex_dREN; assign ifb.idex_dREN = idex_dREN;
    assign ifa.exmem_memreq = exmem_memreq; assign ifb.exmem_memreq = exmem_memreq;
    assign ifa.branch_taken = branch_taken; assign ifb.branch_taken = branch_taken;
    assign ifa.halt = halt;         assign ifb.halt = halt;

    logic [8:0] ctl_a, ctl_b;
    assign ctl_a = {ifa.pc_enable, ifa.ifid_enable, ifa.idex_enable, ifa.exmem_enable, ifa.memwb_enable,
                    ifa.ifid_flush, ifa.idex_flush, ifa.exmem_flush, ifa.memwb_flush};
    assign ctl_b = {ifb.pc_enable, ifb.ifid_enable, ifb.idex_enable, ifb.exmem_enable, ifb.memwb_enable,
                    ifb.ifid_flush, ifb.idex_flush, ifb.exmem_flush, ifb.memwb_flush};

    // Forwarding build with two load-use bubbles.
    hazard_ctrl_p #(.REG_W(5), .BUBBLES(2), .FWD_EN(1)) dut (
        .CLK (CLK),
        .RST (RST),
        .hz  (ifa.slave)
    );

    // No-forwarding build with a single bubble.
    hazard_ctrl_p #(.REG_W(5), .BUBBLES(1), .FWD_EN(0)) dut_nf (
        .CLK (CLK),
        .RST (RST),
        .hz  (ifb.slave)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic idle();
        ihit = 1'b1; dhit = 1'b1;
        ifid_rs = '0; ifid_rt = '0; idex_rs = '0; idex_rt = '0;
        idex_rd = '0; exmem_rd = '0; memwb_rd = '0;
        idex_wen = 1'b0; exmem_wen = 1'b0; memwb_wen = 1'b0;
        idex_dREN = 1'b0; exmem_memreq = 1'b0; branch_taken = 1'b0; halt = 1'b0;
    endtask

    // Advance one clock; inputs change 1 time unit after the edge, checks at +3.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST = 1'b1;
        idle();
        exmem_rd = 5'd5; exmem_wen = 1'b1; idex_rs = 5'd5;
        cyc(); cyc();
        #2;
        chk("rst_ctl", ctl_a, RSTV);
        chk("rst_fwd_a", ifa.fwd_a, 2'b00);
        chk("rst_halted", ifa.halted, 1'b0);
        chk("rst_ctl_nf", ctl_b, RSTV);

        cyc(); RST = 1'b0; idle();
        #2 chk("run", ctl_a, RUNV);

        // Forwarding priority and $0 exclusion.
        cyc();
        exmem_rd = 5'd5; memwb_rd = 5'd5; exmem_wen = 1'b1; memwb_wen = 1'b1; idex_rs = 5'd5;
        #2;
        chk("fwd_exmem", ifa.fwd_a, 2'b01);
        chk("fwd_b_rf", ifa.fwd_b, 2'b00);
        chk("fwd_off_nf", ifb.fwd_a, 2'b00);
        chk("fwd_run", ctl_a, RUNV);
        cyc(); exmem_wen = 1'b0; idex_rt = 5'd5;
        #2;
        chk("fwd_memwb", ifa.fwd_a, 2'b10);
        chk("fwd_b_memwb", ifa.fwd_b, 2'b10);
        cyc(); idex_rs = 5'd0;
        #2 chk("fwd_r0", ifa.fwd_a, 2'b00);

        // Load to $0 is never a hazard.
        cyc(); idle(); idex_dREN = 1'b1; idex_wen = 1'b1; idex_rd = 5'd0;
        #2 chk("lu_r0", ctl_a, RUNV);

        // Load-use, two bubbles: the load leaves EX after the first one.
        cyc(); idle(); idex_dREN = 1'b1; idex_wen = 1'b1; idex_rd = 5'd3; ifid_rs = 5'd3;
        #2 chk("lu_b1", ctl_a, BUBV);
        cyc(); idle(); ifid_rs = 5'd3; exmem_rd = 5'd3; exmem_wen = 1'b1; exmem_memreq = 1'b1;
        #2 chk("lu_b2", ctl_a, BUBV);
        cyc(); idle(); ifid_rs = 5'd3; memwb_rd = 5'd3; memwb_wen = 1'b1;
        #2 chk("lu_done", ctl_a, RUNV);

        // Data miss masks a taken branch until dhit.
        cyc(); idle(); exmem_memreq = 1'b1; dhit = 1'b0; branch_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2 chk($sformatf("miss_%0d", i), ctl_a, HLDV);
            cyc();
        end
        dhit = 1'b1;
        #2 chk("miss_br", ctl_a, BRV);
        cyc(); idle();
        #2 chk("miss_after", ctl_a, RUNV);

        // Branch with a slow target fetch.
        cyc(); idle(); branch_taken = 1'b1;
        #2 chk("bf_br", ctl_a, BRV);
        cyc(); idle(); ihit = 1'b0;
        #2 chk("bf_w1", ctl_a, REFV);
        cyc();
        #2 chk("bf_w2", ctl_a, REFV);
        cyc(); ihit = 1'b1;
        #2 chk("bf_hit", ctl_a, RUNV);
        cyc(); ihit = 1'b0;
        #2 chk("bf_run_hold", ctl_a, HLDV);

        // No forwarding: bubble every cycle while the producer is live.
        cyc(); idle(); memwb_rd = 5'd7; memwb_wen = 1'b1; ifid_rt = 5'd7;
        for (int i = 0; i < 3; i++) begin
            #2 chk($sformatf("nf_bub_%0d", i), ctl_b, BUBV);
            cyc();
        end
        #2 chk("nf_fwd_no_stall", ctl_a, RUNV);
        memwb_wen = 1'b0;
        #2 chk("nf_clear", ctl_b, RUNV);
        cyc(); idle(); exmem_rd = 5'd7; exmem_wen = 1'b1; ifid_rs = 5'd7;
        #2 chk("nf_exmem", ctl_b, BUBV);
        cyc(); idle(); exmem_rd = 5'd0; exmem_wen = 1'b1;
        #2 chk("nf_r0", ctl_b, RUNV);

        // Halt is sticky and outranks a branch until reset.
        cyc(); idle(); halt = 1'b1;
        #2;
        chk("halt_ctl", ctl_a, HLDV);
        chk("halt_flag", ifa.halted, 1'b1);
        cyc(); idle();
        for (int i = 0; i < 3; i++) begin
            branch_taken = (i == 1);
            #2;
            chk($sformatf("halt_ctl_%0d", i), ctl_a, HLDV);
            chk($sformatf("halt_flag_%0d", i), ifa.halted, 1'b1);
            cyc();
        end
        RST = 1'b1;
        #2;
        chk("halt_rst_ctl", ctl_a, RSTV);
        chk("halt_rst_flag", ifa.halted, 1'b0);
        cyc(); RST = 1'b0; idle();
        #2;
        chk("halt_release", ctl_a, RUNV);
        chk("halt_release_flag", ifa.halted, 1'b0);

        // Reset in the middle of a load-use stall.
        cyc(); idle(); idex_dREN = 1'b1; idex_wen = 1'b1; idex_rd = 5'd4; ifid_rt = 5'd4;
        #2 chk("mid_lu", ctl_a, BUBV);
        cyc(); RST = 1'b1;
        #2 chk("mid_rst", ctl_a, RSTV);
        cyc(); RST = 1'b0; idle();
        #2 chk("mid_after", ctl_a, RUNV);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl_p.md
HAZARD_CTRL_P -- requirements
Module: hazard_ctrl_p

Interface
REQ-001 SHALL have parameter REG_W, default 5, register-index width.
REQ-002 SHALL have parameter BUBBLES, default 1, load-use stall cycles; legal range 1..3.
REQ-003 SHALL have parameter FWD_EN, default 1: 1 = forwarding; 0 = stall on any RAW.
REQ-004 SHALL have one clock; reset is synchronous and active-high. Ports:
- CLK  in  1  clock
- RST  in  1  synchronous active-high reset
- ihit, dhit  in  1  instruction/data cache hit
- ifid_rs, ifid_rt  in  REG_W  sources of the instruction in ID
- idex_rs, idex_rt  in  REG_W  sources of the instruction in EX
- idex_rd, exmem_rd, memwb_rd  in  REG_W  destinations per stage
- idex_wen, exmem_wen, memwb_wen  in  1  register write enable per stage
- idex_dREN  in  1  EX instruction is a load
- exmem_memreq  in  1  MEM-stage data request (dREN or dWEN)
- branch_taken  in  1  redirect resolved in MEM
- halt  in  1  halt reached WB
- pc_enable, ifid_enable, idex_enable, exmem_enable, memwb_enable  out  1
- ifid_flush, idex_flush, exmem_flush, memwb_flush  out  1
- fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 EX/MEM, 10 MEM/WB
- halted  out  1  sticky halt status

Function
REQ-005 SHALL define adv = ihit AND NOT (exmem_memreq AND NOT dhit).
REQ-006 SHALL never treat register index 0 as a hazard or forwarding source.
REQ-007 SHALL implement states RUN, LU_STALL, MEM_WAIT, FLUSH, HALTED.
REQ-008 SHALL resolve events in this priority: halt > MEM_WAIT > branch_taken > load-use/RAW > normal.
REQ-009 SHALL, in RUN with adv and no hazard, drive all enables to 1 and all flushes to 0.
REQ-010 SHALL, in any state except HALTED with adv = 0, drive all enables to 0 and all flushes to 0.
REQ-011 SHALL, while exmem_memreq AND NOT dhit, be in MEM_WAIT with all enables 0, and return to RUN the cycle after dhit.
REQ-012 SHALL define load-use as idex_dREN AND idex_wen AND idex_rd != 0 AND idex_rd matching ifid_rs or ifid_rt.
REQ-013 SHALL, on load-use in RUN with adv, drive pc_enable = ifid_enable = 0, idex_flush = 1, and remaining enables 1; this cycle counts as bubble 1.
REQ-014 SHALL, if BUBBLES > 1, enter LU_STALL with counter = BUBBLES-1, repeat the REQ-013 outputs each adv cycle, decrement on adv, and return to RUN when the counter reaches 0.
REQ-015 SHALL, on branch_taken with adv, drive ifid_flush = idex_flush = exmem_flush = 1 and enter FLUSH.
REQ-016 SHALL, in FLUSH, hold ifid_flush = 1 until the first ihit, then return to RUN.
REQ-017 SHALL, with FWD_EN = 0, treat a match of ifid_rs or ifid_rt against any writing idex_rd, exmem_rd or memwb_rd as a REQ-013 bubble, re-evaluated every cycle.
REQ-018 SHALL set fwd_a to 01 on exmem_wen AND exmem_rd == idex_rs != 0, else to 10 on memwb_wen AND memwb_rd == idex_rs != 0, else to 00; fwd_b uses idex_rt; both are 00 when FWD_EN = 0.
REQ-019 SHALL enter HALTED on halt with all enables 0, all flushes 0 and halted = 1, sticky until RST.
REQ-020 SHALL produce outputs combinationally from state and inputs with zero-cycle latency; only state, counter and halted are registered.

Reset
REQ-021 SHALL, while RST = 1, drive all enables 0, all flushes 1, fwd_a = fwd_b = 00 and halted = 0.
REQ-022 SHALL, on RST, set state to RUN and counter to 0 at the clock edge, overriding any state, including mid-stall.

Structure
REQ-023 SHALL place the state enum hazard_state_t and fwd_sel_t (00/01/10) in cpu_types_pkg.
REQ-024 SHALL use one sub-module, hazard_fwd_sel, instantiated once per EX operand.

Verification
REQ-025 Load-use with BUBBLES = 2: idex lw $3, ifid rs = 3, ihit = 1 -> idex_flush = 1 and pc_enable = 0 for exactly 2 cycles, then all enables 1.
REQ-026 Forwarding: exmem_rd = memwb_rd = 5, both wen = 1, idex_rs = 5 -> fwd_a = 01; with exmem_wen = 0 -> fwd_a = 10; with idex_rs = 0 -> 00.
REQ-027 Miss during branch: exmem_memreq = 1, dhit = 0 for 3 cycles, branch_taken = 1 -> no flush for 3 cycles; after dhit, ifid_flush, idex_flush and exmem_flush = 1.
REQ-028 Branch with late fetch: branch_taken, then ihit = 0 for 2 cycles -> ifid_flush stays 1 until ihit, then RUN.
REQ-029 FWD_EN = 0: memwb_rd = 7 with wen, ifid_rt = 7 -> bubble each cycle until memwb_wen = 0.
REQ-030 Halt then RST: halt = 1 -> halted = 1 and enables 0 indefinitely; RST = 1 -> flushes 1; release -> RUN.
